// File: rtl/pixel_frame_streamer_if.sv
// Frame streamer bus: host write port, stream control, pixel output.
// The host drives the master side; the streamer owns the slave side.
interface pixel_frame_streamer_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10
);
  logic              iWrEn;
  logic [ADDR_W-1:0] iWrAddr;
  logic [PIX_W-1:0]  iWrData;
  logic              iStart;
  logic              iHold;
  logic [PIX_W-1:0]  oPixelOut;
  logic              oPixelValid;
  logic              oBusy;
  logic              oFrameDone;

  modport master (
    output iWrEn, iWrAddr, iWrData,
    output iStart, iHold,
    input  oPixelOut, oPixelValid,
    input  oBusy, oFrameDone
  );

  modport slave (
    input  iWrEn, iWrAddr, iWrData,
    input  iStart, iHold,
    output oPixelOut, oPixelValid,
    output oBusy, oFrameDone
  );
endinterface

// File: rtl/pixel_frame_streamer.sv
// Frame buffer that replays an IMG_W x IMG_W frame in raster order,
// with optional per-row idle gaps and a hold stall.
module pixel_frame_streamer #(
  parameter int IMG_W   = 28,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 10,
  parameter int ROW_GAP = 0
) (
  input  logic iClk,
  input  logic iRst,
  pixel_frame_streamer_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_W;
  localparam int CW   = $clog2(IMG_W);
  localparam int GW   = $clog2(ROW_GAP + 2);
  localparam logic [ADDR_W:0] NPIX_A = (ADDR_W + 1)'(NPIX);
  localparam logic [CW-1:0]   LAST   = CW'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE, STREAM, GAP, DONE
  } state_t;

  state_t state, nextState;

  logic [CW-1:0]     row, col;
  logic [GW-1:0]     gapCnt;
  logic [PIX_W-1:0]  mem [NPIX];
  logic [ADDR_W-1:0] rdAddr;
  logic [PIX_W-1:0]  pixel;
  logic              valid;
  logic              emit, lastCol, lastPix;
  logic              gapEnd, busy;

  assign rdAddr  = ADDR_W'(row) * ADDR_W'(IMG_W)
                 + ADDR_W'(col);
  assign lastCol = (col == LAST);
  assign lastPix = lastCol && (row == LAST);
  assign gapEnd  = (int'(gapCnt) == ROW_GAP - 1);
  assign busy    = (state != IDLE);

  assign bus.oPixelOut   = pixel;
  assign bus.oPixelValid = valid;
  assign bus.oBusy       = busy;
  assign bus.oFrameDone  = (state == DONE);

  // Host writes land only while idle and in range; contents survive reset.
  always_ff @(posedge iClk) begin
    if (bus.iWrEn && !busy && ({1'b0, bus.iWrAddr} < NPIX_A))
      mem[bus.iWrAddr] <= bus.iWrData;
  end

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // Next state and pixel-issue decision.
  always_comb begin
    nextState = state;
    emit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.iStart) nextState = STREAM;
      end
      STREAM: begin
        if (!bus.iHold) begin
          emit = 1'b1;
          if (lastPix)
            nextState = DONE;
          else if (lastCol && (ROW_GAP > 0))
            nextState = GAP;
        end
      end
      GAP: begin
        if (gapEnd) nextState = STREAM;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Raster counters, gap timer and the registered pixel output.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      row    <= '0;
      col    <= '0;
      gapCnt <= '0;
      pixel  <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= emit;
      if (emit) pixel <= mem[rdAddr];

      if (state == IDLE && bus.iStart) begin
        row <= '0;
        col <= '0;
      end else if (emit) begin
        if (lastCol) begin
          col <= '0;
          row <= lastPix ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (state == GAP)
        gapCnt <= gapEnd ? '0 : gapCnt + 1'b1;
      else
        gapCnt <= '0;
    end
  end
endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Scoreboard bench: two streamers (no row gap / gap of 2) checked
// against a frame model built from the host-side view of the buffer.
module tb_pixel_frame_streamer;
  localparam int N  = 28;
  localparam int NP = N * N;

  typedef struct {
    logic [7:0] pix;
    logic       last;
    int         gap;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pixel_frame_streamer_if #(.PIX_W(8), .ADDR_W(10)) b0 ();
  pixel_frame_streamer_if #(.PIX_W(8), .ADDR_W(10)) b1 ();

  pixel_frame_streamer #(
    .IMG_W(N), .PIX_W(8), .ADDR_W(10), .ROW_GAP(0)
  ) dut0 (.iClk(clk), .iRst(rst), .bus(b0));

  pixel_frame_streamer #(
    .IMG_W(N), .PIX_W(8), .ADDR_W(10), .ROW_GAP(2)
  ) dut1 (.iClk(clk), .iRst(rst), .bus(b1));

  always #5 clk = ~clk;

  int   nCmp = 0;
  int   nErr = 0;
  ent_t q0[$];
  ent_t q1[$];
  logic [7:0] refMem [NP];
  int   lowRun [2];
  bit   prevDone [2];
  logic hs0 = 1'b0;
  logic hs1 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected frame: values from the model buffer, done on the last pixel,
  // and the number of idle cycles that must precede each pixel (-1 = any).
  task automatic pushFrame(input int d, input int g,
                           input int firstGap, input bit gapChk);
    ent_t e;
    for (int p = 0; p < NP; p++) begin
      e.pix  = refMem[p];
      e.last = (p == NP - 1);
      if (p == 0)      e.gap = firstGap;
      else if (gapChk) e.gap = ((p - 1) % N == N - 1) ? g : 0;
      else             e.gap = -1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [7:0] px,
                     input logic dn, input logic bz, input logic hs);
    ent_t e;
    bit   have;
    if (hs) chk($sformatf("valid_after_hold%0d", d), int'(v), 0);
    if (prevDone[d]) chk($sformatf("busy_after_done%0d", d), int'(bz), 0);
    prevDone[d] = dn;
    if (!v) begin
      chk($sformatf("done_no_valid%0d", d), int'(dn), 0);
      lowRun[d]++;
    end else begin
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        nCmp++;
        nErr++;
        $display("FAIL unexpected_pixel%0d: got %0d expected none", d, px);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("pixel%0d", d), int'(px), int'(e.pix));
        chk($sformatf("done%0d", d), int'(dn), int'(e.last));
        if (e.gap >= 0)
          chk($sformatf("gap%0d", d), lowRun[d], e.gap);
      end
      lowRun[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    hs0 <= b0.iHold;
    hs1 <= b1.iHold;
  end

  always @(negedge clk) begin
    mon(0, b0.oPixelValid, b0.oPixelOut, b0.oFrameDone, b0.oBusy, hs0);
    mon(1, b1.oPixelValid, b1.oPixelOut, b1.oFrameDone, b1.oBusy, hs1);
  end

  task automatic loadAll();
    for (int a = 0; a < NP; a++) begin
      @(negedge clk);
      b0.iWrEn = 1'b1; b0.iWrAddr = 10'(a); b0.iWrData = refMem[a];
      b1.iWrEn = 1'b1; b1.iWrAddr = 10'(a); b1.iWrData = refMem[a];
    end
    @(negedge clk);
    b0.iWrEn = 1'b0;
    b1.iWrEn = 1'b0;
  endtask

  task automatic startPulse(input int d);
    @(negedge clk);
    if (d == 0) b0.iStart = 1'b1; else b1.iStart = 1'b1;
    @(negedge clk);
    b0.iStart = 1'b0;
    b1.iStart = 1'b0;
  endtask

  task automatic drain(input int d, input int limit, input bit rndHold);
    int  n = 0;
    bit  act = 1'b1;
    while (act && n < limit) begin
      @(negedge clk);
      n++;
      if (rndHold) b0.iHold = 1'($urandom_range(0, 1));
      if (d == 0) act = (q0.size() != 0) || b0.oBusy;
      else        act = (q1.size() != 0) || b1.oBusy;
    end
    b0.iHold = 1'b0;
    chk($sformatf("drain_in_time%0d", d), int'(n < limit), 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    b0.iWrEn = 0; b0.iWrAddr = 0; b0.iWrData = 0;
    b0.iStart = 0; b0.iHold = 0;
    b1.iWrEn = 0; b1.iWrAddr = 0; b1.iWrData = 0;
    b1.iStart = 0; b1.iHold = 0;
    lowRun[0] = 0; lowRun[1] = 0;

    #1 rst = 1'b1;
    #1;
    chk("rst_pix", int'(b0.oPixelOut), 0);
    chk("rst_valid", int'(b0.oPixelValid), 0);
    chk("rst_busy", int'(b0.oBusy), 0);
    chk("rst_done", int'(b0.oFrameDone), 0);
    chk("rst_busy1", int'(b1.oBusy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp frame, back-to-back pixels, first-pixel latency.
    for (int a = 0; a < NP; a++) refMem[a] = 8'(a % 256);
    loadAll();
    pushFrame(0, 0, -1, 1'b1);
    startPulse(0);
    chk("lat_valid_e0", int'(b0.oPixelValid), 0);
    chk("lat_busy", int'(b0.oBusy), 1);
    @(negedge clk);
    chk("lat_valid_e1", int'(b0.oPixelValid), 1);
    drain(0, 2000, 1'b0);

    // Row gaps of two cycles.
    pushFrame(1, 2, -1, 1'b1);
    startPulse(1);
    drain(1, 2000, 1'b0);

    // Out-of-range write while idle, then start and write mid-frame.
    @(negedge clk);
    b0.iWrEn = 1'b1; b0.iWrAddr = 10'd784; b0.iWrData = 8'h55;
    @(negedge clk);
    b0.iWrEn = 1'b0;
    pushFrame(0, 0, -1, 1'b1);
    startPulse(0);
    n = 0;
    while (q0.size() > NP - 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    b0.iStart = 1'b1;
    b0.iWrEn = 1'b1; b0.iWrAddr = 10'd0; b0.iWrData = 8'hAA;
    @(negedge clk);
    b0.iStart = 1'b0;
    b0.iWrEn = 1'b0;
    drain(0, 2000, 1'b0);
    pushFrame(0, 0, -1, 1'b1);
    startPulse(0);
    drain(0, 2000, 1'b0);

    // Random contents; random hold stalls.
    for (int a = 0; a < NP; a++) refMem[a] = 8'($urandom_range(0, 255));
    loadAll();
    pushFrame(0, 0, -1, 1'b0);
    startPulse(0);
    drain(0, 4000, 1'b1);
    pushFrame(1, 2, -1, 1'b1);
    startPulse(1);
    drain(1, 2000, 1'b0);

    // Reset mid-frame, then replay from the retained buffer.
    pushFrame(0, 0, -1, 1'b1);
    startPulse(0);
    n = 0;
    while (q0.size() > NP - 101 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pixel100", int'(n < 400), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete();
    #1;
    chk("arst_pix", int'(b0.oPixelOut), 0);
    chk("arst_valid", int'(b0.oPixelValid), 0);
    chk("arst_busy", int'(b0.oBusy), 0);
    chk("arst_done", int'(b0.oFrameDone), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pushFrame(0, 0, -1, 1'b1);
    startPulse(0);
    drain(0, 2000, 1'b0);

    // iStart held: two frames separated by exactly two idle cycles.
    pushFrame(0, 0, -1, 1'b1);
    pushFrame(0, 0, 2, 1'b1);
    @(negedge clk);
    b0.iStart = 1'b1;
    n = 0;
    while (q0.size() >= NP && n < 2000) begin
      @(negedge clk);
      n++;
    end
    b0.iStart = 1'b0;
    chk("second_frame_began", int'(n < 2000), 1);
    drain(0, 2000, 1'b0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
